// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage RISC-V pipeline.
// Holds the program counter, a word-addressed instruction memory with a
// boot/bench write port, and the IF/ID pipeline register feeding decode.
//
// Optional build macro FETCH_STATS_EN adds saturating fetch and stall
// counters. Without it both counter outputs are tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 256,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pc_enable,
   input  logic        if_id_enable,
   input  logic        mux_sel_IF,
   input  logic [31:0] pc_branch_value,
   input  logic        imem_we,
   input  logic [31:0] imem_addr,
   input  logic [31:0] imem_wdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   // IMEM_WORDS must be a power of two (>= 2) so the index slice wraps cleanly.
   localparam int unsigned IdxW = $clog2(IMEM_WORDS);

   logic [31:0]     pc_reg;
   logic [31:0]     pc_next;
   logic [31:0]     imem [IMEM_WORDS];
   logic [IdxW-1:0] rd_idx;
   logic [IdxW-1:0] wr_idx;
   logic [31:0]     fetch_word;

   // Address bits outside the word index are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{imem_addr[31:IdxW+2], imem_addr[1:0]};

   assign rd_idx     = pc_reg[IdxW+1:2];
   assign wr_idx     = imem_addr[IdxW+1:2];
   assign fetch_word = imem[rd_idx];

   // Instruction memory write port; contents survive reset.
   always_ff @(posedge clock) begin
      if (imem_we) begin
         imem[wr_idx] <= imem_wdata;
      end
   end

   // Next-PC select: a frozen PC ignores redirects in the same cycle.
   always_comb begin
      pc_next = pc_reg;
      if (pc_enable) begin
         if (mux_sel_IF) begin
            pc_next = pc_branch_value;
         end else begin
            pc_next = pc_reg + 32'd4;
         end
      end
   end

   // Program counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   // IF/ID register: stall beats flush, flush inserts a bubble.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instruction <= NOP_INSTR;
         pc          <= 32'd0;
         if_id_valid <= 1'b0;
      end else if (if_id_enable) begin
         if (mux_sel_IF) begin
            instruction <= NOP_INSTR;
            pc          <= 32'd0;
            if_id_valid <= 1'b0;
         end else begin
            instruction <= fetch_word;
            pc          <= pc_reg;
            if_id_valid <= 1'b1;
         end
      end
   end

`ifdef FETCH_STATS_EN
   logic        fetch_inc;
   logic        stall_inc;
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   // A real fetch lands in IF/ID exactly when it is enabled and not flushed.
   assign fetch_inc = if_id_enable && !mux_sel_IF;
   assign stall_inc = !if_id_enable;

   // Saturating statistics counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   assign fetch_count = 32'd0;
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        pc_enable;
   logic        if_id_enable;
   logic        mux_sel_IF;
   logic [31:0] pc_branch_value;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        if_id_valid;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clock           (clock),
      .reset           (reset),
      .pc_enable       (pc_enable),
      .if_id_enable    (if_id_enable),
      .mux_sel_IF      (mux_sel_IF),
      .pc_branch_value (pc_branch_value),
      .imem_we         (imem_we),
      .imem_addr       (imem_addr),
      .imem_wdata      (imem_wdata),
      .instruction     (instruction),
      .pc              (pc),
      .if_id_valid     (if_id_valid),
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ev);
      chk({tag, ".instr"}, instruction, ei);
      chk({tag, ".pc"}, pc, ep);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, ev});
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      imem_addr  = a;
      imem_wdata = d;
      imem_we    = 1'b1;
      step();
      imem_we    = 1'b0;
   endtask

   initial begin
      pc_enable       = 1'b1;
      if_id_enable    = 1'b1;
      mux_sel_IF      = 1'b0;
      pc_branch_value = 32'd0;
      imem_we         = 1'b0;
      imem_addr       = 32'd0;
      imem_wdata      = 32'd0;
      reset           = 1'b1;
      #1 reset = 1'b0;
      #1;
      chk_ifid("reset", NOP, 32'd0, 1'b0);
      chk("reset.fetch_count", fetch_count, 32'd0);
      chk("reset.stall_count", stall_count, 32'd0);

      // Load program while held in reset.
      wr(32'h0000_0000, 32'h0000_0011);
      wr(32'h0000_0004, 32'h0000_0022);
      wr(32'h0000_0008, 32'h0000_0033);
      wr(32'h0000_000C, 32'h0000_0044);
      wr(32'h0000_0040, 32'h0000_00AA);
      wr(32'h0000_03FC, 32'h0000_0055);
      chk_ifid("in_reset", NOP, 32'd0, 1'b0);

      reset = 1'b1;
      chk_ifid("released", NOP, 32'd0, 1'b0);
      step(); chk_ifid("f0", 32'h11, 32'h0, 1'b1);
      step(); chk_ifid("f1", 32'h22, 32'h4, 1'b1);
      step(); chk_ifid("f2", 32'h33, 32'h8, 1'b1);
      step(); chk_ifid("f3", 32'h44, 32'hC, 1'b1);

      // Branch to 0x40: one bubble then the target.
      mux_sel_IF = 1'b1; pc_branch_value = 32'h40;
      step(); chk_ifid("br_bubble", NOP, 32'd0, 1'b0);
      mux_sel_IF = 1'b0;
      step(); chk_ifid("br_target", 32'hAA, 32'h40, 1'b1);

      // Redirect to 4, then stall three cycles with a flush attempt on the last.
      mux_sel_IF = 1'b1; pc_branch_value = 32'h4;
      step(); chk_ifid("to4_bubble", NOP, 32'd0, 1'b0);
      mux_sel_IF = 1'b0;
      pc_enable = 1'b0; if_id_enable = 1'b0;
      step(); chk_ifid("stall1", NOP, 32'd0, 1'b0);
      step(); chk_ifid("stall2", NOP, 32'd0, 1'b0);
      mux_sel_IF = 1'b1; pc_branch_value = 32'h80;
      step(); chk_ifid("stall3_flush", NOP, 32'd0, 1'b0);
      mux_sel_IF = 1'b0;
      pc_enable = 1'b1; if_id_enable = 1'b1;
      chk("stall_count", stall_count, STATS ? 32'd3 : 32'd0);
      step(); chk_ifid("resume", 32'h22, 32'h4, 1'b1);
      step(); chk_ifid("resume2", 32'h33, 32'h8, 1'b1);
      chk("fetch_count7", fetch_count, STATS ? 32'd7 : 32'd0);

      // Index wrap at the top of memory.
      mux_sel_IF = 1'b1; pc_branch_value = 32'h3FC;
      step(); chk_ifid("wrap_bubble", NOP, 32'd0, 1'b0);
      mux_sel_IF = 1'b0;
      step(); chk_ifid("wrap_last", 32'h55, 32'h3FC, 1'b1);
      step(); chk_ifid("wrap_first", 32'h11, 32'h400, 1'b1);

      // Same-edge write to the addressed word (pc_reg=0x404 -> word 1).
      pc_enable = 1'b0;
      imem_addr = 32'h4; imem_wdata = 32'h99; imem_we = 1'b1;
      step(); chk_ifid("wr_old", 32'h22, 32'h404, 1'b1);
      imem_we = 1'b0; pc_enable = 1'b1;
      step(); chk_ifid("wr_new", 32'h99, 32'h404, 1'b1);
      chk("fetch_count11", fetch_count, STATS ? 32'd11 : 32'd0);

      // Asynchronous reset mid-cycle.
      #2 reset = 1'b0;
      #1;
      chk_ifid("async_rst", NOP, 32'd0, 1'b0);
      chk("async_rst.fetch_count", fetch_count, 32'd0);
      chk("async_rst.stall_count", stall_count, 32'd0);
      step();
      reset = 1'b1;
      step(); chk_ifid("persist0", 32'h11, 32'h0, 1'b1);
      step(); chk_ifid("persist1", 32'h99, 32'h4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
